// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read-side stream stage.
// Buffer-state encodings, the default word width and the statistics counter widths.
package fifo_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int STAT_WORDS_W   = 32;
  localparam int STAT_STALL_W   = 16;

  // Encoding equals the number of words currently held in the skid buffer
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry register buffer with head/tail pointers and an occupancy FSM.
// It accepts push and pop in the same cycle, including while full.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              r_clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output buf_state_e        state
);

  logic [DATA_W-1:0] mem_reg [2];
  logic              head_reg;
  logic              tail_reg;
  buf_state_e        state_reg;
  buf_state_e        state_next;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BUF_EMPTY: if (push) state_next = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      state_next = BUF_TWO;
        else if (pop && !push) state_next = BUF_EMPTY;
      end
      BUF_TWO:   if (pop && !push) state_next = BUF_ONE;
      default:   state_next = BUF_EMPTY;
    endcase
  end

  // When full, tail and head point at the same slot, so a push
  // during a pop lands in the slot the head is just leaving.
  always_ff @(posedge r_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= BUF_EMPTY;
      head_reg   <= 1'b0;
      tail_reg   <= 1'b0;
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
    end else begin
      state_reg <= state_next;
      if (push) begin
        mem_reg[tail_reg] <= push_data;
        tail_reg          <= ~tail_reg;
      end
      if (pop) head_reg <= ~head_reg;
    end
  end

  assign head_data = mem_reg[head_reg];
  assign state     = state_reg;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side output stage: issues FIFO reads and re-presents the words as a valid/ready stream.
// Optional statistics counters are built when RD_STREAM_STATS_EN is defined.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                    r_clk,
  input  logic                    reset_n,
  input  logic                    fifo_empty,
  output logic                    fifo_rd,
  input  logic [DATA_W-1:0]       fifo_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W-1:0]       m_data
`ifdef RD_STREAM_STATS_EN
  ,
  output logic [STAT_WORDS_W-1:0] stat_words,
  output logic [STAT_STALL_W-1:0] stat_stalls
`endif
);

  buf_state_e buf_state;
  logic [1:0] buf_cnt;
  logic       inflight_reg;
  logic       pop;
  logic [2:0] occ_next;

  rd_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .r_clk     (r_clk),
    .reset_n   (reset_n),
    .push      (inflight_reg),
    .push_data (fifo_rdata),
    .pop       (pop),
    .head_data (m_data),
    .state     (buf_state)
  );

  assign buf_cnt = buf_state;
  assign m_valid = (buf_state != BUF_EMPTY);
  assign pop     = m_valid & m_ready;

  // Occupancy after this edge, counting the word still in the memory read pipe
  assign occ_next = {1'b0, buf_cnt} + {2'b00, inflight_reg} - {2'b00, pop};
  assign fifo_rd  = reset_n & ~fifo_empty & (occ_next < 3'd2);

  always_ff @(posedge r_clk or negedge reset_n) begin
    if (!reset_n) inflight_reg <= 1'b0;
    else          inflight_reg <= fifo_rd;
  end

  assert property (@(posedge r_clk) disable iff (!reset_n)
                   (({1'b0, buf_cnt} + {2'b00, inflight_reg}) <= 3'd2));

`ifdef RD_STREAM_STATS_EN
  logic [STAT_WORDS_W-1:0] words_reg;
  logic [STAT_STALL_W-1:0] stalls_reg;

  always_ff @(posedge r_clk or negedge reset_n) begin
    if (!reset_n) begin
      words_reg  <= '0;
      stalls_reg <= '0;
    end else begin
      if (pop && (words_reg != '1))                    words_reg  <= words_reg + 1'b1;
      if (m_valid && !m_ready && (stalls_reg != '1))   stalls_reg <= stalls_reg + 1'b1;
    end
  end

  assign stat_words  = words_reg;
  assign stat_stalls = stalls_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based stream model plus directed scenarios.
// Stats ports are connected and checked when RD_STREAM_STATS_EN is defined.
module tb_fifo_rd_stream;

  localparam int DW = 8;

  logic          r_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_rdata = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
`ifdef RD_STREAM_STATS_EN
  logic [31:0]   stat_words;
  logic [15:0]   stat_stalls;
`endif

  fifo_rd_stream #(.DATA_W(DW)) dut (
    .r_clk       (r_clk),
    .reset_n     (reset_n),
    .fifo_empty  (fifo_empty),
    .fifo_rd     (fifo_rd),
    .fifo_rdata  (fifo_rdata),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data)
`ifdef RD_STREAM_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_stalls (stat_stalls)
`endif
  );

  always #5 r_clk = ~r_clk;

  int checks = 0;
  int errors = 0;

  // FIFO environment: contents, level and an override to force empty
  logic          force_empty = 1'b0;
  int            fifo_level = 0;
  logic [DW-1:0] env_q[$];
  assign fifo_empty = force_empty || (fifo_level == 0);

  // Reference model state: words expected in the buffer and the one in the read pipe
  logic [DW-1:0] mdl_fifo[$];
  logic [DW-1:0] mbuf[$];
  logic [DW-1:0] exp_stream[$];
  logic          mpend = 1'b0;
  logic [DW-1:0] mpend_data = '0;
  longint        m_words = 0;
  int            m_stalls = 0;

  // Observation logs used by the directed checks
  logic [DW-1:0] got[$];
  int            pop_cyc[$];
  int            cyc = 0;
  int            rd_count = 0;
  int            first_rd = -1;
  int            first_valid = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    env_q.push_back(w);
    mdl_fifo.push_back(w);
    exp_stream.push_back(w);
    fifo_level++;
  endtask

  task automatic clear_logs();
    got.delete();
    pop_cyc.delete();
    rd_count    = 0;
    first_rd    = -1;
    first_valid = -1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge r_clk);
    #1;
  endtask

  task automatic wait_got(input int n, input string name);
    for (int i = 0; i < 60 && got.size() < n; i++) step(1);
    check(name, 64'(got.size()), 64'(n));
  endtask

  // FIFO memory: a read issued in one cycle returns its word in the next
  initial begin
    logic env_rd;
    forever begin
      @(negedge r_clk);
      env_rd = fifo_rd;
      @(posedge r_clk);
      #1;
      if (env_rd && reset_n && env_q.size() > 0) begin
        fifo_rdata = env_q.pop_front();
        fifo_level--;
      end
    end
  end

  // Per-cycle compare against the model, then advance the model at the clock edge
  initial begin
    logic          active;
    logic          exp_valid;
    logic          mpop;
    logic          exp_rd;
    int            occ;
    logic [DW-1:0] w;
    forever begin
      @(negedge r_clk);
      cyc++;
      active    = reset_n;
      exp_valid = 1'b0;
      mpop      = 1'b0;
      exp_rd    = 1'b0;
      if (!reset_n) begin
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data",  m_data, 0);
      end else begin
        exp_valid = (mbuf.size() != 0);
        mpop      = exp_valid && m_ready;
        occ       = mbuf.size() + int'(mpend) - int'(mpop);
        exp_rd    = !fifo_empty && (occ < 2);
        check("fifo_rd", fifo_rd, exp_rd);
        check("m_valid", m_valid, exp_valid);
        if (exp_valid) check("m_data", m_data, mbuf[0]);
        if (fifo_rd) begin
          rd_count++;
          if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
          got.push_back(m_data);
          pop_cyc.push_back(cyc);
          if (exp_stream.size() == 0) check("order_extra", m_data, 64'hDEAD);
          else check("order", m_data, exp_stream.pop_front());
        end
      end
`ifdef RD_STREAM_STATS_EN
      check("stat_words",  stat_words,  64'(m_words));
      check("stat_stalls", stat_stalls, 64'(m_stalls));
`endif
      @(posedge r_clk);
      if (!reset_n) begin
        mbuf.delete();
        mpend    = 1'b0;
        m_words  = 0;
        m_stalls = 0;
      end else if (active) begin
        if (mpop) void'(mbuf.pop_front());
        if (mpend) mbuf.push_back(mpend_data);
        mpend = exp_rd;
        if (exp_rd) begin
          w          = (mdl_fifo.size() > 0) ? mdl_fifo.pop_front() : '0;
          mpend_data = w;
        end
        if (mpop && m_words < 64'hFFFF_FFFF) m_words++;
        if (exp_valid && !m_ready && m_stalls < 16'hFFFF) m_stalls++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] t2 [3] = '{8'h11, 8'h22, 8'h33};
  logic [DW-1:0] t3 [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
  logic [DW-1:0] t4 [6] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};

  initial begin
    // 1: reset held with the FIFO non-empty
    push_word(8'h5A);
    step(3);
    check("t1_rd_in_reset", fifo_rd, 0);
    check("t1_valid_in_reset", m_valid, 0);
    reset_n = 1'b1;
    @(negedge r_clk);
    check("t1_rd_after_release", fifo_rd, 1);
    step(1);
    m_ready = 1'b1;
    wait_got(1, "t1_count");
    check("t1_word", got[0], 8'h5A);
    step(3);

    // 2: three words, always ready
    clear_logs();
    push_word(t2[0]); push_word(t2[1]); push_word(t2[2]);
    wait_got(3, "t2_count");
    for (int i = 0; i < 3; i++) check("t2_word", got[i], t2[i]);
    check("t2_rd_pulses", 64'(rd_count), 3);
    check("t2_latency", 64'(first_valid - first_rd), 2);
    check("t2_back_to_back", 64'(pop_cyc[2] - pop_cyc[0]), 2);
    step(3);

    // 3: five words queued behind back-pressure
    clear_logs();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(t3[i]);
    step(10);
    check("t3_rd_pulses_held", 64'(rd_count), 2);
    check("t3_valid_held", m_valid, 1);
    check("t3_head_held", m_data, 8'hA1);
    m_ready = 1'b1;
    wait_got(5, "t3_count");
    for (int i = 0; i < 5; i++) check("t3_word", got[i], t3[i]);
    step(3);

    // 4: ready toggling with continuous data
    clear_logs();
    for (int i = 0; i < 6; i++) push_word(t4[i]);
    for (int i = 0; i < 12; i++) begin
      m_ready = (i % 2 == 0);
      step(1);
    end
    m_ready = 1'b1;
    wait_got(6, "t4_count");
    for (int i = 0; i < 6; i++) check("t4_word", got[i], t4[i]);
    step(3);

    // 5: empty asserts the cycle after a read issue
    clear_logs();
    push_word(8'hC1); push_word(8'hC2);
    @(negedge r_clk);
    step(1);
    force_empty = 1'b1;
    step(4);
    check("t5_rd_while_empty", 64'(rd_count), 1);
    check("t5_captured", 64'(got.size()), 1);
    check("t5_word0", got[0], 8'hC1);
    force_empty = 1'b0;
    wait_got(2, "t5_count");
    check("t5_word1", got[1], 8'hC2);
    step(3);

    // 6: asynchronous reset with the buffer full
    clear_logs();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'hD1 + 8'(i));
    step(6);
    check("t6_full_valid", m_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", m_valid, 0);
    check("t6_async_data", m_data, 0);
    env_q.delete();
    mdl_fifo.delete();
    exp_stream.delete();
    fifo_level = 0;
    step(2);
    reset_n = 1'b1;
    step(1);
`ifdef RD_STREAM_STATS_EN
    check("t6_stat_words", stat_words, 0);
    check("t6_stat_stalls", stat_stalls, 0);
`endif
    check("t6_valid_after", m_valid, 0);
    clear_logs();
    m_ready = 1'b1;
    push_word(8'hE1);
    wait_got(1, "t6_count");
    check("t6_word", got[0], 8'hE1);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
